dcache_port_arbiter: RTL and testbench
======================================

DCACHE_PORT_ARBITER -- requirements
Module: dcache_port_arbiter

Interface
REQ-001 SHALL have parameter TAG_W, default 13, reqtag width.
REQ-002 SHALL have parameter STARVE_MAX, default 4, consecutive read losses before read is forced to win.
REQ-003 SHALL have port clk  in  1  sole clock, all state on posedge.
REQ-004 SHALL have port reset  in  1  synchronous, active-low (reset==0 at posedge clk resets).
REQ-005 SHALL have ports rd_reqcyc in 1, rd_req in 64, rd_reqtag in TAG_W  read requester (memory stage) request.
REQ-006 SHALL have ports rd_reqack out 1, rd_respcyc out 1, rd_resp out 64  read requester ack/response.
REQ-007 SHALL have ports wr_reqcyc in 1, wr_req in 64, wr_reqdata in 64, wr_reqtag in TAG_W  write requester (writeback) request.
REQ-008 SHALL have ports wr_reqack out 1, wr_writeack out 1  write requester acks.
REQ-009 SHALL have ports m_reqcyc out 1, m_req out 64, m_reqdata out 64, m_reqtag out TAG_W  shared dcache request.
REQ-010 SHALL have ports m_reqack in 1, m_respcyc in 1, m_resp in 64, m_writeack in 1, m_respack out 1  shared dcache acks/response.
REQ-011 SHALL have ports busy out 1 (transaction outstanding), grant_wr out 1 (write owns port).

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, WAIT_RD, WAIT_WR; exactly one transaction outstanding.
REQ-013 IDLE, no reqcyc asserted: SHALL remain IDLE, m_reqcyc=0.
REQ-014 IDLE, one reqcyc asserted: SHALL grant it, latch its req/reqdata/reqtag into m_* registers, assert m_reqcyc next cycle, enter ISSUE.
REQ-015 IDLE, both asserted: write SHALL win unless starve counter==STARVE_MAX, then read wins.
REQ-016 Starve counter SHALL increment (saturating at STARVE_MAX) each write grant while rd_reqcyc=1; clear on read grant.
REQ-017 m_reqdata SHALL be 0 for read grants; m_req/m_reqdata/m_reqtag SHALL hold stable from grant until next grant.
REQ-018 ISSUE: m_reqcyc SHALL stay 1 until m_reqack=1; winner's reqack SHALL equal m_reqack combinationally that cycle (one-cycle pulse).
REQ-019 ISSUE with m_reqack=1: m_reqcyc SHALL be 0 next cycle; next state WAIT_RD (read) or WAIT_WR (write).
REQ-020 WAIT_RD with m_respcyc=1: rd_respcyc=1, rd_resp=m_resp, m_respack=1, all combinational same cycle; next state IDLE.
REQ-021 WAIT_WR with m_writeack=1: wr_writeack=1 same cycle; next state IDLE.
REQ-022 m_reqack outside ISSUE, m_respcyc outside WAIT_RD, m_writeack outside WAIT_WR SHALL be ignored; m_respack=0 there.
REQ-023 Requester dropping reqcyc after grant SHALL NOT abort; transaction completes, acks still pulsed.
REQ-024 Loser's reqack/response outputs SHALL stay 0 throughout.
REQ-025 Re-arbitration SHALL occur only in IDLE; minimum cycles grant-to-grant = 3 (IDLE, ISSUE, WAIT).
REQ-026 busy SHALL be 1 in any state but IDLE; grant_wr SHALL be 1 from write grant until return to IDLE.
REQ-027 Response in same cycle as m_reqack SHALL NOT be accepted; dcache responds no earlier than cycle after reqack.

Reset
REQ-028 reset==0 at posedge: state IDLE, starve counter 0, m_reqcyc 0, m_req/m_reqdata/m_reqtag 0, busy 0, grant_wr 0.
REQ-029 All combinational ack/response outputs SHALL be 0 while state IDLE, hence 0 during and after reset.
REQ-030 reset mid-transaction SHALL abandon it silently; no reqack/respcyc/writeack pulse to any requester.

Verification
REQ-031 Read only: rd_req=0x1000; m_reqack 2 cycles later, m_resp=0xDEAD after 3 more -> rd_reqack 1 pulse, rd_resp=0xDEAD with rd_respcyc, m_respack same cycle.
REQ-032 Write only: wr_req=0x2000, wr_reqdata=0x55 -> m_reqdata=0x55, grant_wr=1; m_writeack -> wr_writeack pulse, busy 0 next cycle.
REQ-033 Both held continuously, STARVE_MAX=4 -> grant order W,W,W,W,R,W,W,W,W,R.
REQ-034 Both assert same cycle, counter 0 -> write granted; rd_reqack stays 0 until read's own ISSUE.
REQ-035 reset=0 during WAIT_RD -> next cycle IDLE, m_reqcyc 0, late m_respcyc ignored (rd_respcyc 0).
REQ-036 wr_reqcyc dropped in ISSUE -> m_reqcyc held, wr_reqack and wr_writeack still pulse.

Source files
------------

// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter: shares one dcache port between the memory-stage reader
// and the writeback writer, one transaction in flight, write-priority with read starvation guard.
module dcache_port_arbiter #(
  parameter int TAG_W      = 13,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rd_reqcyc,
  input  logic [63:0]      rd_req,
  input  logic [TAG_W-1:0] rd_reqtag,
  output logic             rd_reqack,
  output logic             rd_respcyc,
  output logic [63:0]      rd_resp,
  input  logic             wr_reqcyc,
  input  logic [63:0]      wr_req,
  input  logic [63:0]      wr_reqdata,
  input  logic [TAG_W-1:0] wr_reqtag,
  output logic             wr_reqack,
  output logic             wr_writeack,
  output logic             m_reqcyc,
  output logic [63:0]      m_req,
  output logic [63:0]      m_reqdata,
  output logic [TAG_W-1:0] m_reqtag,
  input  logic             m_reqack,
  input  logic             m_respcyc,
  input  logic [63:0]      m_resp,
  input  logic             m_writeack,
  output logic             m_respack,
  output logic             busy,
  output logic             grant_wr
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    WAIT_WR
  } state_t;

  state_t        state;
  state_t        stateNxt;
  logic [CW-1:0] starveCnt;
  logic          isWr;
  logic          grantRd;
  logic          grantWr;
  logic          readForce;

  assign readForce = rd_reqcyc && (starveCnt == SMAX);
  assign m_reqcyc  = (state == ISSUE);
  assign busy      = (state != IDLE);
  assign grant_wr  = isWr && busy;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= stateNxt;
  end

  // Arbitration, next state and winner-only handshakes; acks muted in reset
  always_comb begin
    stateNxt    = state;
    grantRd     = 1'b0;
    grantWr     = 1'b0;
    rd_reqack   = 1'b0;
    rd_respcyc  = 1'b0;
    rd_resp     = 64'd0;
    wr_reqack   = 1'b0;
    wr_writeack = 1'b0;
    m_respack   = 1'b0;
    unique case (state)
      IDLE: begin
        grantWr = wr_reqcyc && !readForce;
        grantRd = rd_reqcyc && !grantWr;
        if (grantWr || grantRd) stateNxt = ISSUE;
      end
      ISSUE: begin
        if (m_reqack) begin
          stateNxt  = isWr ? WAIT_WR : WAIT_RD;
          rd_reqack = reset && !isWr;
          wr_reqack = reset && isWr;
        end
      end
      WAIT_RD: begin
        if (m_respcyc) begin
          stateNxt = IDLE;
          if (reset) begin
            rd_respcyc = 1'b1;
            rd_resp    = m_resp;
            m_respack  = 1'b1;
          end
        end
      end
      WAIT_WR: begin
        if (m_writeack) begin
          stateNxt    = IDLE;
          wr_writeack = reset;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  // Latch winner's request and track read starvation at grant time
  always_ff @(posedge clk) begin
    if (!reset) begin
      m_req     <= 64'd0;
      m_reqdata <= 64'd0;
      m_reqtag  <= '0;
      isWr      <= 1'b0;
      starveCnt <= '0;
    end else if (grantWr) begin
      m_req     <= wr_req;
      m_reqdata <= wr_reqdata;
      m_reqtag  <= wr_reqtag;
      isWr      <= 1'b1;
      if (rd_reqcyc && starveCnt != SMAX)
        starveCnt <= starveCnt + 1'b1;
    end else if (grantRd) begin
      m_req     <= rd_req;
      m_reqdata <= 64'd0;
      m_reqtag  <= rd_reqtag;
      isWr      <= 1'b0;
      starveCnt <= '0;
    end
  end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// tb_dcache_port_arbiter: directed vectors for the dcache port arbiter,
// expected values computed by hand.
module tb_dcache_port_arbiter;

  localparam int TAG_W = 13;

  logic             clk = 1'b0;
  logic             reset;
  logic             rd_reqcyc;
  logic [63:0]      rd_req;
  logic [TAG_W-1:0] rd_reqtag;
  logic             rd_reqack;
  logic             rd_respcyc;
  logic [63:0]      rd_resp;
  logic             wr_reqcyc;
  logic [63:0]      wr_req;
  logic [63:0]      wr_reqdata;
  logic [TAG_W-1:0] wr_reqtag;
  logic             wr_reqack;
  logic             wr_writeack;
  logic             m_reqcyc;
  logic [63:0]      m_req;
  logic [63:0]      m_reqdata;
  logic [TAG_W-1:0] m_reqtag;
  logic             m_reqack;
  logic             m_respcyc;
  logic [63:0]      m_resp;
  logic             m_writeack;
  logic             m_respack;
  logic             busy;
  logic             grant_wr;

  int nCmp = 0;
  int nBad = 0;

  always #5 clk = ~clk;

  dcache_port_arbiter #(.TAG_W(TAG_W), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .rd_reqcyc(rd_reqcyc), .rd_req(rd_req), .rd_reqtag(rd_reqtag),
    .rd_reqack(rd_reqack), .rd_respcyc(rd_respcyc), .rd_resp(rd_resp),
    .wr_reqcyc(wr_reqcyc), .wr_req(wr_req), .wr_reqdata(wr_reqdata),
    .wr_reqtag(wr_reqtag), .wr_reqack(wr_reqack), .wr_writeack(wr_writeack),
    .m_reqcyc(m_reqcyc), .m_req(m_req), .m_reqdata(m_reqdata),
    .m_reqtag(m_reqtag), .m_reqack(m_reqack), .m_respcyc(m_respcyc),
    .m_resp(m_resp), .m_writeack(m_writeack), .m_respack(m_respack),
    .busy(busy), .grant_wr(grant_wr)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Both requesters held; run one full transaction, check the winner
  task automatic runOne(input int idx, input logic expWr);
    string t;
    t = $sformatf("arb%0d", idx);
    step();
    chk({t, "_grantwr"}, grant_wr, expWr);
    chk({t, "_mreq"}, m_req, expWr ? 64'h4000 : 64'h3000);
    m_reqack = 1'b1;
    #1;
    chk({t, "_rdack"}, rd_reqack, !expWr);
    chk({t, "_wrack"}, wr_reqack, expWr);
    step();
    m_reqack = 1'b0;
    if (expWr) m_writeack = 1'b1;
    else begin
      m_respcyc = 1'b1;
      m_resp    = 64'h77;
    end
    #1;
    chk({t, "_rdresp"}, rd_respcyc, !expWr);
    chk({t, "_wrwack"}, wr_writeack, expWr);
    step();
    m_writeack = 1'b0;
    m_respcyc  = 1'b0;
    #1;
    chk({t, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    logic [9:0] order;
    order      = 10'b1111011110;
    reset      = 1'b0;
    rd_reqcyc  = 1'b0;
    rd_req     = '0;
    rd_reqtag  = '0;
    wr_reqcyc  = 1'b0;
    wr_req     = '0;
    wr_reqdata = '0;
    wr_reqtag  = '0;
    m_reqack   = 1'b0;
    m_respcyc  = 1'b0;
    m_resp     = '0;
    m_writeack = 1'b0;
    step();
    step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_grantwr", grant_wr, 1'b0);
    chk("rst_mreqcyc", m_reqcyc, 1'b0);
    chk("rst_mreq", m_req, 64'd0);
    chk("rst_mtag", m_reqtag, 64'd0);
    reset = 1'b1;

    // Read only
    rd_reqcyc = 1'b1;
    rd_req    = 64'h1000;
    rd_reqtag = 13'd5;
    #1;
    chk("rd_idle_noreq", m_reqcyc, 1'b0);
    step();
    chk("rd_mreqcyc", m_reqcyc, 1'b1);
    chk("rd_mreq", m_req, 64'h1000);
    chk("rd_mdata", m_reqdata, 64'd0);
    chk("rd_mtag", m_reqtag, 64'd5);
    chk("rd_busy", busy, 1'b1);
    chk("rd_noack", rd_reqack, 1'b0);
    step();
    chk("rd_hold", m_reqcyc, 1'b1);
    m_reqack  = 1'b1;
    m_respcyc = 1'b1;
    m_resp    = 64'hBEEF;
    #1;
    chk("rd_ack", rd_reqack, 1'b1);
    chk("rd_wrack0", wr_reqack, 1'b0);
    chk("rd_earlyresp", rd_respcyc, 1'b0);
    step();
    m_reqack  = 1'b0;
    m_respcyc = 1'b0;
    rd_reqcyc = 1'b0;
    #1;
    chk("rd_mreqcyc0", m_reqcyc, 1'b0);
    chk("rd_ackpulse", rd_reqack, 1'b0);
    step();
    step();
    m_respcyc = 1'b1;
    m_resp    = 64'hDEAD;
    #1;
    chk("rd_respcyc", rd_respcyc, 1'b1);
    chk("rd_resp", rd_resp, 64'hDEAD);
    chk("rd_respack", m_respack, 1'b1);
    step();
    m_respcyc = 1'b0;
    #1;
    chk("rd_done", busy, 1'b0);

    // Write only, requester drops in ISSUE
    wr_reqcyc  = 1'b1;
    wr_req     = 64'h2000;
    wr_reqdata = 64'h55;
    wr_reqtag  = 13'd7;
    step();
    chk("wr_mdata", m_reqdata, 64'h55);
    chk("wr_mreq", m_req, 64'h2000);
    chk("wr_grant", grant_wr, 1'b1);
    wr_reqcyc = 1'b0;
    step();
    chk("wr_hold", m_reqcyc, 1'b1);
    m_reqack = 1'b1;
    #1;
    chk("wr_ack", wr_reqack, 1'b1);
    chk("wr_rdack0", rd_reqack, 1'b0);
    step();
    m_reqack = 1'b0;
    #1;
    chk("wr_grant2", grant_wr, 1'b1);
    chk("wr_stable", m_reqdata, 64'h55);
    m_writeack = 1'b1;
    #1;
    chk("wr_wack", wr_writeack, 1'b1);
    chk("wr_respack0", m_respack, 1'b0);
    step();
    m_writeack = 1'b0;
    #1;
    chk("wr_busy0", busy, 1'b0);
    chk("wr_grant0", grant_wr, 1'b0);

    // Stray dcache signals in IDLE
    m_reqack   = 1'b1;
    m_respcyc  = 1'b1;
    m_writeack = 1'b1;
    #1;
    chk("ign_resp", rd_respcyc, 1'b0);
    chk("ign_wack", wr_writeack, 1'b0);
    chk("ign_respack", m_respack, 1'b0);
    step();
    chk("ign_busy", busy, 1'b0);
    m_reqack   = 1'b0;
    m_respcyc  = 1'b0;
    m_writeack = 1'b0;

    // Both held: W,W,W,W,R,W,W,W,W,R
    rd_reqcyc = 1'b1;
    rd_req    = 64'h3000;
    wr_reqcyc = 1'b1;
    wr_req    = 64'h4000;
    for (int i = 0; i < 10; i++) runOne(i, order[9-i]);
    rd_reqcyc = 1'b0;
    wr_reqcyc = 1'b0;
    step();

    // Reset during WAIT_RD
    rd_reqcyc = 1'b1;
    rd_req    = 64'h5000;
    step();
    m_reqack = 1'b1;
    step();
    m_reqack  = 1'b0;
    rd_reqcyc = 1'b0;
    reset     = 1'b0;
    m_respcyc = 1'b1;
    m_resp    = 64'h99;
    #1;
    chk("rst_mid_resp", rd_respcyc, 1'b0);
    chk("rst_mid_respack", m_respack, 1'b0);
    step();
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_mreqcyc", m_reqcyc, 1'b0);
    chk("rst_mid_mreq", m_req, 64'd0);
    reset = 1'b1;
    #1;
    chk("rst_late_resp", rd_respcyc, 1'b0);
    step();
    chk("rst_late_busy", busy, 1'b0);
    m_respcyc = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
